// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR signature compactor and its
// single-step update block.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } misr_state_e;

  localparam int              MISR_WIDTH        = 9;
  localparam logic [MISR_WIDTH-1:0] MISR_POLY_DEFAULT = 9'h011;
  localparam logic [MISR_WIDTH-1:0] MISR_SEED_DEFAULT = 9'h000;

endpackage

// File: rtl/misr_step.sv
// One combinational MISR update: shift the signature by one position,
// fold the feedback bit in through the tap mask, then XOR in the data word.
module misr_step
  import misr_pkg::*;
#(
  parameter int              WIDTH = MISR_WIDTH,
  parameter logic [WIDTH-1:0] POLY = MISR_POLY_DEFAULT
) (
  input  logic [WIDTH-1:0] sig_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig_out
);

  logic fb;

  // Bit 0 always takes the feedback (x^0 term), so POLY[0] is not consulted.
  always_comb begin
    fb         = sig_in[WIDTH-1];
    sig_out    = '0;
    sig_out[0] = fb ^ data_in[0];
    for (int i = 1; i < WIDTH; i++) begin
      sig_out[i] = sig_in[i-1] ^ (POLY[i] & fb) ^ data_in[i];
    end
  end

endmodule

// File: rtl/misr_compactor.sv
// MISR response compactor: folds a counted run of response words into a
// signature, then compares it once against a golden value.
module misr_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH = MISR_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = MISR_POLY_DEFAULT,
  parameter logic [WIDTH-1:0] SEED  = MISR_SEED_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        pattern_count,
  input  logic               resp_valid,
  input  logic [0:WIDTH-1]   resp_data,
  input  logic [WIDTH-1:0]   golden,
  output logic               resp_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [WIDTH-1:0]   signature,
  output logic [15:0]        accepted
);

  misr_state_e      state, state_next;
  logic [15:0]      count_q;
  logic [15:0]      acc_next;
  logic [WIDTH-1:0] data_word;
  logic [WIDTH-1:0] sig_step;
  logic             beat;
  logic             last_beat;

  // resp_data is MSB-first; reorder so data_word[i] is the x^i coefficient.
  always_comb begin
    data_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      data_word[i] = resp_data[WIDTH-1-i];
    end
  end

  misr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .sig_in  (signature),
    .data_in (data_word),
    .sig_out (sig_step)
  );

  assign beat      = (state == RUN) && resp_valid;
  assign acc_next  = accepted + 16'd1;
  assign last_beat = beat && (acc_next == count_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = (pattern_count == 16'd0) ? CHECK : RUN;
      RUN:        if (last_beat) state_next = CHECK;
      CHECK:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_ready = (state == RUN);
    busy       = (state == RUN) || (state == CHECK);
    done       = (state == DONE);
  end

  // Result flags are cleared on start so they can only be high in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature <= SEED;
      accepted  <= 16'd0;
      count_q   <= 16'd0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            signature <= SEED;
            accepted  <= 16'd0;
            count_q   <= pattern_count;
            pass      <= 1'b0;
            fail      <= 1'b0;
          end
        end
        RUN: begin
          if (beat) begin
            signature <= sig_step;
            accepted  <= acc_next;
          end
        end
        CHECK: begin
          pass <= (signature == golden);
          fail <= (signature != golden);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor: a polynomial-shift model predicts each
// session's signature and verdict, queued for comparison when done rises.
module tb_misr_compactor;

  localparam logic [8:0] POLY   = 9'h011;
  localparam logic [8:0] SEED_S = 9'h100;

  typedef struct {
    bit         inst;
    logic [8:0] sig;
    logic [15:0] acc;
    logic       pass;
    logic       fail;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] pattern_count;
  logic        resp_valid;
  logic [0:8]  resp_data;
  logic [8:0]  golden;

  logic        resp_ready, busy, done, pass, fail;
  logic [8:0]  signature;
  logic [15:0] accepted;
  logic        resp_ready_s, busy_s, done_s, pass_s, fail_s;
  logic [8:0]  signature_s;
  logic [15:0] accepted_s;

  int          checks;
  int          failures;
  exp_t        sb[$];
  logic [8:0]  m0, m1, gold4;
  logic [15:0] macc, mcnt;
  bit          model_run;

  misr_compactor dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pattern_count (pattern_count),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .golden        (golden),
    .resp_ready    (resp_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .signature     (signature),
    .accepted      (accepted)
  );

  misr_compactor #(.SEED(SEED_S)) dut_s (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pattern_count (pattern_count),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .golden        (golden),
    .resp_ready    (resp_ready_s),
    .busy          (busy_s),
    .done          (done_s),
    .pass          (pass_s),
    .fail          (fail_s),
    .signature     (signature_s),
    .accepted      (accepted_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial view: multiply by x, reduce by x^9 = POLY (x^0 always set).
  function automatic logic [8:0] model_step(input logic [8:0] s, input logic [8:0] d);
    logic [8:0] n;
    n = {s[7:0], 1'b0};
    if (s[8]) n = n ^ (POLY | 9'h001);
    return n ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected();
    sb.push_back('{inst: 1'b0, sig: m0, acc: macc, pass: (m0 == golden), fail: (m0 != golden)});
    sb.push_back('{inst: 1'b1, sig: m1, acc: macc, pass: (m1 == golden), fail: (m1 != golden)});
  endtask

  task automatic startSession(input logic [15:0] cnt, input logic [8:0] gold);
    golden        = gold;
    pattern_count = cnt;
    start         = 1'b1;
    tick();
    start     = 1'b0;
    m0        = 9'h000;
    m1        = SEED_S;
    macc      = 16'd0;
    mcnt      = cnt;
    model_run = (cnt != 16'd0);
    if (cnt == 16'd0) pushExpected();
  endtask

  task automatic applyStimulus(input logic valid, input logic [8:0] v);
    resp_valid = valid;
    resp_data  = v;
    tick();
    resp_valid = 1'b0;
    if (valid && model_run) begin
      m0   = model_step(m0, v);
      m1   = model_step(m1, v);
      macc = macc + 16'd1;
      if (macc == mcnt) begin
        model_run = 1'b0;
        pushExpected();
      end
    end
  endtask

  // Called on the cycle the DUT is expected to be in CHECK; done follows one edge later.
  task automatic waitDone(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, n, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.inst) begin
        checkOutput({tag, "_sig"},  signature, e.sig);
        checkOutput({tag, "_acc"},  accepted,  e.acc);
        checkOutput({tag, "_pass"}, pass,      e.pass);
        checkOutput({tag, "_fail"}, fail,      e.fail);
      end else begin
        checkOutput({tag, "_sig_s"},  signature_s, e.sig);
        checkOutput({tag, "_pass_s"}, pass_s,      e.pass);
        checkOutput({tag, "_fail_s"}, fail_s,      e.fail);
      end
    end
  endtask

  initial begin
    logic [8:0] vals[6];
    logic       vlds[6];
    checks        = 0;
    failures      = 0;
    model_run     = 1'b0;
    m0            = '0;
    m1            = '0;
    macc          = '0;
    mcnt          = '0;
    rst           = 1'b1;
    start         = 1'b0;
    pattern_count = '0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    golden        = '0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_busy",    busy,        0);
    checkOutput("rst_ready",   resp_ready,  0);
    checkOutput("rst_done",    done,        0);
    checkOutput("rst_passfail", {pass, fail}, 0);
    checkOutput("rst_sig",     signature,   9'h000);
    checkOutput("rst_sig_s",   signature_s, 9'h100);
    checkOutput("rst_acc",     accepted,    0);

    // Single word 9'h001 from seed 0 reproduces itself.
    startSession(16'd1, 9'h001);
    checkOutput("t1_ready", resp_ready, 1);
    checkOutput("t1_busy",  busy,       1);
    applyStimulus(1'b1, 9'h001);
    checkOutput("t1_sig_const", signature, 9'h001);
    checkOutput("t1_in_check",  {resp_ready, busy, done}, 3'b010);
    waitDone("t1");
    checkOutput("t1_pass_const", pass, 1);

    // DONE holds against stray resp_valid.
    applyStimulus(1'b1, 9'h1FF);
    checkOutput("hold_sig",  signature, 9'h001);
    checkOutput("hold_acc",  accepted,  1);
    checkOutput("hold_done", {done, pass, fail}, 3'b110);

    // Seed 9'h100 with a zero word exercises the x^4 tap.
    startSession(16'd1, 9'h000);
    applyStimulus(1'b1, 9'h000);
    checkOutput("t2_sig_s_const", signature_s, 9'h011);
    waitDone("t2");
    checkOutput("t2_fail_s_const", fail_s, 1);

    // Zero-length session goes straight through CHECK.
    startSession(16'd0, 9'h000);
    checkOutput("t3_in_check", {resp_ready, busy, done}, 3'b010);
    waitDone("t3");
    checkOutput("t3_acc0", accepted, 0);

    // Gapped valid stream: only four beats count.
    vals = '{9'h1A5, 9'h0FF, 9'h033, 9'h155, 9'h1C0, 9'h07E};
    vlds = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gold4 = 9'h000;
    for (int i = 0; i < 6; i++) begin
      if (vlds[i]) gold4 = model_step(gold4, vals[i]);
    end
    startSession(16'd4, gold4);
    for (int i = 0; i < 6; i++) applyStimulus(vlds[i], vals[i]);
    waitDone("t4");
    checkOutput("t4_acc4", accepted, 4);

    // Reset mid-RUN abandons the session.
    startSession(16'd5, 9'h000);
    applyStimulus(1'b1, 9'h0AA);
    applyStimulus(1'b1, 9'h155);
    checkOutput("t5_acc2", accepted, 2);
    rst        = 1'b1;
    start      = 1'b1;
    resp_valid = 1'b1;
    tick();
    rst        = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    model_run  = 1'b0;
    checkOutput("t5_state", {resp_ready, busy, done}, 3'b000);
    checkOutput("t5_sig",   signature,   9'h000);
    checkOutput("t5_sig_s", signature_s, 9'h100);
    checkOutput("t5_acc",   accepted,    0);
    checkOutput("t5_passfail", {pass, fail}, 0);

    // resp_valid in IDLE, and start during RUN, are ignored.
    applyStimulus(1'b1, 9'h0F0);
    checkOutput("t6_idle_sig", signature, 9'h000);
    checkOutput("t6_idle_acc", accepted,  0);
    startSession(16'd3, 9'h000);
    applyStimulus(1'b1, 9'h123);
    pattern_count = 16'd1;
    start         = 1'b1;
    applyStimulus(1'b1, 9'h0C3);
    start = 1'b0;
    checkOutput("t6_run_acc",   accepted,   2);
    checkOutput("t6_run_ready", resp_ready, 1);
    checkOutput("t6_run_sig",   signature,  m0);
    applyStimulus(1'b1, 9'h1E1);
    waitDone("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
